// File: rtl/seq_cnt_pkg.sv
// Shared constants, state/command enums and constant helpers for the seq_counter block.
package seq_cnt_pkg;

  localparam int MAX_LEN = 32;

  localparam int PRIMES [MAX_LEN] = '{
    2, 3, 5, 7, 11, 13, 17, 19, 23, 29, 31, 37, 41, 43, 47, 53,
    59, 61, 67, 71, 73, 79, 83, 89, 97, 101, 103, 107, 109, 113, 127, 131
  };

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    SEEK = 1'b1
  } state_e;

  typedef enum logic [2:0] {
    FIB_HOLD  = 3'd0,
    FIB_UP    = 3'd1,
    FIB_DOWN  = 3'd2,
    FIB_CLEAR = 3'd3,
    FIB_TOP   = 3'd4
  } fib_cmd_e;

  function automatic int fib(input int n);
    int a;
    int b;
    int t;
    a = 0;
    b = 1;
    for (int i = 0; i < n; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  function automatic int prime_at(input int n);
    logic [4:0] k;
    k = 5'(n);
    return PRIMES[k];
  endfunction

  // Bits needed to hold the largest term either sequence can present.
  function automatic int need_width(input int len);
    int m;
    m = (fib(len - 1) > prime_at(len - 1)) ? fib(len - 1) : prime_at(len - 1);
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/seq_cnt_fib_core.sv
// Fibonacci register pair cur=F(i), nxt=F(i+1) with step/clear/preset commands.
module seq_cnt_fib_core
  import seq_cnt_pkg::*;
#(
  parameter int LEN   = 11,
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  fib_cmd_e         cmd,
  output logic [WIDTH-1:0] cur_next
);

  localparam int PW = WIDTH + 1;
  localparam logic [WIDTH:0] TOP_CUR = PW'(fib(LEN - 1));
  localparam logic [WIDTH:0] TOP_NXT = PW'(fib(LEN));
  localparam logic [WIDTH:0] ONE     = {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH:0] cur_r;
  logic [WIDTH:0] nxt_r;
  logic [WIDTH:0] cur_n_s;
  logic [WIDTH:0] nxt_n_s;

  // Next pair value for the requested command
  always_comb begin
    cur_n_s = cur_r;
    nxt_n_s = nxt_r;
    case (cmd)
      FIB_UP: begin
        cur_n_s = nxt_r;
        nxt_n_s = cur_r + nxt_r;
      end
      FIB_DOWN: begin
        cur_n_s = nxt_r - cur_r;
        nxt_n_s = cur_r;
      end
      FIB_CLEAR: begin
        cur_n_s = '0;
        nxt_n_s = ONE;
      end
      FIB_TOP: begin
        cur_n_s = TOP_CUR;
        nxt_n_s = TOP_NXT;
      end
      default: begin
        cur_n_s = cur_r;
        nxt_n_s = nxt_r;
      end
    endcase
  end

  // Pair register
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_r <= '0;
      nxt_r <= ONE;
    end else begin
      cur_r <= cur_n_s;
      nxt_r <= nxt_n_s;
    end
  end

  assign cur_next = cur_n_s[WIDTH-1:0];

endmodule

// File: rtl/seq_counter.sv
// Modulo-LEN Fibonacci/prime up/down counter with seek-based index load and wrap pulse.
// Defining SEQ_CNT_SAT_EN adds the sat port (stop at the ends instead of wrapping).
module seq_counter
  import seq_cnt_pkg::*;
#(
  parameter int LEN   = 11,
  parameter int WIDTH = 6,
  parameter int IDX_W = $clog2(LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_down,
  input  logic             prime_fib,
  input  logic             load,
  input  logic [IDX_W-1:0] load_idx,
`ifdef SEQ_CNT_SAT_EN
  input  logic             sat,
`endif
  output logic             busy,
  output logic             load_err,
  output logic             wrap,
  output logic [IDX_W-1:0] idx,
  output logic [WIDTH-1:0] Q
);

  if (LEN < 2 || LEN > MAX_LEN) begin : g_bad_len
    $error("seq_counter: LEN must be in 2..%0d", MAX_LEN);
  end
  if (WIDTH < need_width(LEN)) begin : g_bad_width
    $error("seq_counter: WIDTH too small for LEN");
  end

  localparam logic [IDX_W:0]   LEN_V    = (IDX_W + 1)'(LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LEN - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  logic sat_s;
`ifdef SEQ_CNT_SAT_EN
  assign sat_s = sat;
`else
  assign sat_s = 1'b0;
`endif

  state_e           state_r, state_next_s;
  logic [IDX_W-1:0] idx_r, idx_next_s;
  logic [IDX_W-1:0] target_r, target_next_s;
  logic [WIDTH-1:0] q_r, q_next_s, fib_q_s, prime_q_s;
  logic             q_upd_s;
  logic             busy_r, busy_next_s;
  logic             wrap_r, wrap_next_s;
  logic             load_err_r, load_err_next_s;
  fib_cmd_e         cmd_s;

  seq_cnt_fib_core #(
    .LEN   (LEN),
    .WIDTH (WIDTH)
  ) u_fib (
    .clk      (clk),
    .rst      (rst),
    .cmd      (cmd_s),
    .cur_next (fib_q_s)
  );

  // Next-state, index step, pair command and pulse decisions
  always_comb begin
    state_next_s    = state_r;
    idx_next_s      = idx_r;
    target_next_s   = target_r;
    cmd_s           = FIB_HOLD;
    q_upd_s         = 1'b0;
    busy_next_s     = 1'b0;
    wrap_next_s     = 1'b0;
    load_err_next_s = 1'b0;
    case (state_r)
      RUN: begin
        q_upd_s = 1'b1;
        if (load) begin
          if ({1'b0, load_idx} >= LEN_V) begin
            load_err_next_s = 1'b1;
          end else begin
            idx_next_s    = '0;
            cmd_s         = FIB_CLEAR;
            target_next_s = load_idx;
            if (load_idx != '0) begin
              // Q keeps its pre-load value until the seek completes
              state_next_s = SEEK;
              q_upd_s      = 1'b0;
            end else begin
              state_next_s = RUN;
            end
          end
        end else if (en) begin
          if (up_down) begin
            if (idx_r == LAST_IDX) begin
              if (sat_s) begin
                q_upd_s = 1'b0;
              end else begin
                idx_next_s  = '0;
                cmd_s       = FIB_CLEAR;
                wrap_next_s = 1'b1;
              end
            end else begin
              idx_next_s = idx_r + IDX_ONE;
              cmd_s      = FIB_UP;
            end
          end else begin
            if (idx_r == '0) begin
              if (sat_s) begin
                q_upd_s = 1'b0;
              end else begin
                idx_next_s  = LAST_IDX;
                cmd_s       = FIB_TOP;
                wrap_next_s = 1'b1;
              end
            end else begin
              idx_next_s = idx_r - IDX_ONE;
              cmd_s      = FIB_DOWN;
            end
          end
        end else begin
          cmd_s = FIB_HOLD;
        end
      end
      SEEK: begin
        idx_next_s = idx_r + IDX_ONE;
        cmd_s      = FIB_UP;
        if (idx_next_s == target_r) begin
          state_next_s = RUN;
          q_upd_s      = 1'b1;
        end else begin
          busy_next_s = 1'b1;
        end
      end
      default: begin
        state_next_s = RUN;
      end
    endcase
  end

  assign prime_q_s = WIDTH'(prime_at(int'(idx_next_s)));
  assign q_next_s  = prime_fib ? prime_q_s : fib_q_s;

  // State, index and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= RUN;
      idx_r      <= '0;
      target_r   <= '0;
      q_r        <= '0;
      busy_r     <= 1'b0;
      wrap_r     <= 1'b0;
      load_err_r <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      idx_r      <= idx_next_s;
      target_r   <= target_next_s;
      if (q_upd_s) begin
        q_r <= q_next_s;
      end
      busy_r     <= busy_next_s;
      wrap_r     <= wrap_next_s;
      load_err_r <= load_err_next_s;
    end
  end

  assign busy     = busy_r;
  assign wrap     = wrap_r;
  assign load_err = load_err_r;
  assign idx      = idx_r;
  assign Q        = q_r;

endmodule

// File: tb/tb_seq_counter.sv
// Scoreboard bench for seq_counter: driver pushes expected per-edge outputs, monitor compares.
module tb_seq_counter;

  localparam int LEN   = 11;
  localparam int WIDTH = 6;
  localparam int IDX_W = $clog2(LEN);
`ifdef SEQ_CNT_SAT_EN
  localparam bit SAT_BUILD = 1'b1;
`else
  localparam bit SAT_BUILD = 1'b0;
`endif

  typedef struct {
    int    idx;
    int    q;
    bit    busy;
    bit    wrap;
    bit    lerr;
    string tag;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst, en, up_down, prime_fib, load, sat;
  logic [IDX_W-1:0] load_idx;
  logic             busy, load_err, wrap;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] Q;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   m_idx = 0;
  int   m_q   = 0;

  always #5 clk = ~clk;

  seq_counter #(.LEN(LEN), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .up_down   (up_down),
    .prime_fib (prime_fib),
    .load      (load),
    .load_idx  (load_idx),
`ifdef SEQ_CNT_SAT_EN
    .sat       (sat),
`endif
    .busy      (busy),
    .load_err  (load_err),
    .wrap      (wrap),
    .idx       (idx),
    .Q         (Q)
  );

  function automatic int fib_ref(input int n);
    int a, b, t;
    a = 0;
    b = 1;
    for (int i = 0; i < n; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  function automatic int nth_prime(input int n);
    int cnt;
    bit p;
    cnt = 0;
    for (int v = 2; v < 1000; v++) begin
      p = 1'b1;
      for (int d = 2; d * d <= v; d++) begin
        if (v % d == 0) p = 1'b0;
      end
      if (p) begin
        if (cnt == n) return v;
        cnt++;
      end
    end
    return -1;
  endfunction

  function automatic int val(input int i, input bit pf);
    return pf ? nth_prime(i) : fib_ref(i);
  endfunction

  task automatic check(input string tag, input string field, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s %s: got %0d expected %0d", tag, field, act, exp);
    end
  endtask

  task automatic push_exp(input int i, input int qv, input bit b, input bit w, input bit le,
                          input string tag);
    exp_t e;
    e.idx  = i;
    e.q    = qv;
    e.busy = b;
    e.wrap = w;
    e.lerr = le;
    e.tag  = tag;
    sbq.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Load with nonzero target: idx walks 0..L, Q held until the final step, busy on steps 1..L-1.
  task automatic do_seek(input int L, input string tag, input int abort_at);
    push_exp(0, m_q, 1'b0, 1'b0, 1'b0, tag);
    m_idx = 0;
    tick();
    for (int k = 1; k <= L; k++) begin
      en       = 1'($urandom);
      load     = 1'($urandom);
      load_idx = IDX_W'($urandom);
      up_down  = 1'($urandom);
      sat      = 1'($urandom);
      if (k == abort_at) begin
        rst   = 1'b1;
        m_idx = 0;
        m_q   = 0;
        push_exp(0, 0, 1'b0, 1'b0, 1'b0, {tag, "_rst"});
        tick();
        rst  = 1'b0;
        load = 1'b0;
        en   = 1'b0;
        return;
      end
      m_idx = k;
      if (k == L) m_q = val(L, prime_fib);
      push_exp(k, m_q, k < L, 1'b0, 1'b0, tag);
      tick();
    end
    load = 1'b0;
    en   = 1'b0;
  endtask

  // One edge with the current inputs, evaluated by the counting rules
  task automatic run_edge(input string tag);
    bit w, le, hold;
    w    = 1'b0;
    le   = 1'b0;
    hold = 1'b0;
    if (rst) begin
      m_idx = 0;
      m_q   = 0;
      push_exp(0, 0, 1'b0, 1'b0, 1'b0, tag);
      tick();
      return;
    end
    if (load) begin
      if (int'(load_idx) >= LEN) begin
        le = 1'b1;
      end else if (int'(load_idx) == 0) begin
        m_idx = 0;
      end else begin
        do_seek(int'(load_idx), tag, 0);
        return;
      end
    end else if (en) begin
      if (up_down) begin
        if (m_idx == LEN - 1) begin
          if (SAT_BUILD && sat) hold = 1'b1;
          else begin m_idx = 0; w = 1'b1; end
        end else m_idx = m_idx + 1;
      end else begin
        if (m_idx == 0) begin
          if (SAT_BUILD && sat) hold = 1'b1;
          else begin m_idx = LEN - 1; w = 1'b1; end
        end else m_idx = m_idx - 1;
      end
    end
    if (!hold) m_q = val(m_idx, prime_fib);
    push_exp(m_idx, m_q, 1'b0, w, le, tag);
    tick();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check(e.tag, "idx", int'(idx), e.idx);
        check(e.tag, "Q", int'(Q), e.q);
        check(e.tag, "busy", int'(busy), int'(e.busy));
        check(e.tag, "wrap", int'(wrap), int'(e.wrap));
        check(e.tag, "load_err", int'(load_err), int'(e.lerr));
      end
    end
  end

  initial begin : driver
    rst = 1'b1; en = 1'b0; up_down = 1'b1; prime_fib = 1'b0;
    load = 1'b0; load_idx = '0; sat = 1'b0;
    run_edge("reset");
    run_edge("reset");
    rst = 1'b0;

    prime_fib = 1'b1; en = 1'b1; up_down = 1'b1;
    repeat (12) run_edge("prime_up");

    rst = 1'b1;
    run_edge("reset2");
    rst = 1'b0;
    prime_fib = 1'b0; en = 1'b1; up_down = 1'b0;
    repeat (12) run_edge("fib_down");

    en = 1'b0; load = 1'b1; load_idx = IDX_W'(7);
    run_edge("load7");
    run_edge("after_load7");

    load = 1'b1; load_idx = IDX_W'(12);
    run_edge("load_err");
    load = 1'b0;
    run_edge("after_err");
    load = 1'b1; load_idx = IDX_W'(3); en = 1'b1; up_down = 1'b1;
    run_edge("load_vs_en");

    load = 1'b1; load_idx = IDX_W'(5); prime_fib = 1'b0;
    run_edge("load5");
    en = 1'b0; load = 1'b0;
    prime_fib = 1'b1;
    run_edge("pf_to_prime");
    prime_fib = 1'b0;
    run_edge("pf_to_fib");

    load = 1'b1; load_idx = IDX_W'(10);
    run_edge("load10");
    sat = 1'b1; en = 1'b1; up_down = 1'b1;
    run_edge("sat_top");
    sat = 1'b0; en = 1'b0;

    load = 1'b1; load_idx = IDX_W'(7);
    do_seek(7, "seek_rst", 3);
    run_edge("post_abort");

    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 49) == 0);
      load      = ($urandom_range(0, 7) == 0);
      load_idx  = IDX_W'($urandom_range(0, 15));
      en        = ($urandom_range(0, 3) != 0);
      up_down   = 1'($urandom);
      sat       = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 4) == 0) prime_fib = ~prime_fib;
      run_edge("random");
    end
    rst = 1'b0; load = 1'b0; en = 1'b0;

    for (int i = 0; i < 5 && sbq.size() > 0; i++) @(posedge clk);
    #2;
    n_cmp++;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_counter.md
# seq_counter

Parametrised successor to the two-stage Fibonacci/prime up/down counter. It steps a modulo-LEN term index up or down and outputs the index-th Fibonacci number (computed iteratively in a register pair) or the index-th prime (constant table). It adds three things: a random-access index load with a multi-cycle seek, a wrap pulse, and an optional saturate mode. Sits wherever the old counter did, driving displays or test comparators.

## Interface
- LEN, 11: sequence length (terms 0..LEN-1); legal 2..32
- WIDTH, 6: output width; elaboration error if WIDTH < bits of max(F(LEN-1), prime(LEN-1))
- IDX_W, $clog2(LEN): index width (derived, not overridden)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- en  in  1  advance index one step per clock when high
- up_down  in  1  1 = increment, 0 = decrement
- prime_fib  in  1  1 = prime sequence, 0 = Fibonacci
- load  in  1  request jump to load_idx
- load_idx  in  IDX_W  target index for load
- sat  in  1  (only with SEQ_CNT_SAT_EN) 1 = stop at ends instead of wrapping
- busy  out  1  seek in progress; en/load ignored
- load_err  out  1  one-cycle pulse: load_idx >= LEN, request dropped
- wrap  out  1  one-cycle pulse after an index wrap
- idx  out  IDX_W  current term index
- Q  out  WIDTH  current term value

## Operation
- Internal state: idx, Fibonacci pair cur=F(idx), nxt=F(idx+1) held at WIDTH+1 bits, target, FSM {RUN, SEEK}.
- RUN, en=1, up_down=1:
  - idx<LEN-1: idx+1; (cur,nxt) <= (nxt, cur+nxt).
  - idx=LEN-1: idx <= 0; (cur,nxt) <= (0,1); wrap pulses.
- RUN, en=1, up_down=0:
  - idx>0: idx-1; (cur,nxt) <= (nxt-cur, cur).
  - idx=0: idx <= LEN-1; (cur,nxt) <= (F(LEN-1), F(LEN)) constants; wrap pulses.
- Load in RUN (priority over en):
  - load_idx >= LEN: ignore, pulse load_err.
  - Otherwise: idx <= 0, (cur,nxt) <= (0,1), target <= load_idx. Go to SEEK if load_idx != 0, else stay RUN.
- SEEK: step up once per clock regardless of en. busy=1. When the stepped idx equals target, return to RUN. en, load and up_down are ignored. Seek steps never raise wrap.
- Q is registered. Every edge in RUN (including en=0), Q <= prime_fib ? prime[idx_next] : cur_next[WIDTH-1:0].
- Q holds its pre-load value throughout SEEK and is updated on the exit edge.
- A prime_fib change takes effect on the next edge and never disturbs idx or the Fibonacci pair.

## Timing
- Reset values: idx=0, cur=0, nxt=1, Q=0, busy=0, wrap=0, load_err=0, state RUN.
- The first edge after reset loads Q for index 0 in the current mode (0 or 2).
- Step latency: idx and Q change on the same edge that samples en.
- Load latency: busy rises on the edge after load and stays high for load_idx-1 cycles. idx=load_idx and the new Q are valid load_idx cycles after the sampling edge, which is also when busy falls. load_idx=0 gives a 1-cycle load with busy never high.
- rst mid-seek aborts immediately to reset values.
- wrap and load_err are high exactly one cycle.

## Configuration
- SEQ_CNT_SAT_EN defined: the sat port exists. With sat=1, a step that would wrap instead leaves idx, the pair, and Q unchanged, and wrap stays 0.
- SEQ_CNT_SAT_EN undefined: no sat port; the counter always wraps.

## Structure
- seq_cnt_pkg contains:
  - MAX_LEN=32
  - the prime table for the first 32 primes
  - constant function fib(n) used for the wrap constants and the WIDTH check
  - the state enum {RUN, SEEK}
- Sub-module seq_cnt_fib_core holds the cur/nxt pair with step-up, step-down, clear and preset-to-top commands. The top level contains the FSM, idx, the Q register, and the pulse outputs.

## Test plan
- Reset, prime_fib=1, en=1, up_down=1, 12 clocks -> Q = 2,3,5,7,11,13,17,19,23,29,31,2; wrap high on the 11th step.
- Reset, prime_fib=0, up_down=0, en=1 -> Q = 0,55,34,21,13,8,5,3,2,1,1,0; wrap after the first step.
- In RUN, load=1 with load_idx=7 -> busy high 6 cycles; idx=7 and Q=13 (Fib) when busy falls; en pulses during busy have no effect.
- load_idx=12 -> load_err pulse; idx and Q unchanged. load and en together -> load wins.
- At idx=5, Fib, en=0, toggle prime_fib -> Q goes 5 to 13 to 5 on successive edges; idx stays 5.
- With SEQ_CNT_SAT_EN and sat=1, up at idx 10 -> idx stays 10, Q=55, wrap=0. rst asserted mid-seek -> all outputs at reset values next cycle.
